data_bus_xbar: RTL and testbench

- Parametrised successor to the fixed two-target data-bus decoder.
- Routes one RI5CY-style data port (req/gnt/rvalid) to NUM_SLAVES targets through a parametrised base/mask address map.
- Tracks up to MAX_OUTST outstanding transactions in order, so pipelined slaves are legal.
- Answers unmapped addresses with an error response and flags slave protocol violations.

---
 rtl/data_bus_pkg.sv | 39 +++
 rtl/xbar_resp_fifo.sv | 83 ++++++++
 rtl/data_bus_xbar.sv | 141 ++++++++++++++
 tb/tb_data_bus_xbar.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_pkg.sv
// ---------------------------------------------------------------------------
// data_bus_pkg
// Shared definitions for the data-bus crossbar:
//   - default address map of the four standard targets (mem, spi, gpin, gpout)
//     packed into the flat base/mask vectors the crossbar expects
//   - encoding of the "error" response slot kept in the response FIFO
//   - width helper for the FIFO entry that holds a slave index or ERR
// ---------------------------------------------------------------------------
package data_bus_pkg;

    // Default target address map. Slave 0 is the memory, then spi, gpin, gpout.
    localparam logic [31:0] MEM_BASE   = 32'h0010_0000;
    localparam logic [31:0] MEM_MASK   = 32'hFFFF_8000;
    localparam logic [31:0] SPI_BASE   = 32'h2000_0000;
    localparam logic [31:0] SPI_MASK   = 32'hFFFF_F000;
    localparam logic [31:0] GPIN_BASE  = 32'h2000_1000;
    localparam logic [31:0] GPIN_MASK  = 32'hFFFF_F000;
    localparam logic [31:0] GPOUT_BASE = 32'h2000_2000;
    localparam logic [31:0] GPOUT_MASK = 32'hFFFF_F000;

    localparam int DEF_NUM_SLAVES = 4;

    // Flat vectors, slave i in bits [32i+31:32i].
    localparam logic [DEF_NUM_SLAVES*32-1:0] DEF_SLV_BASE =
        {GPOUT_BASE, GPIN_BASE, SPI_BASE, MEM_BASE};
    localparam logic [DEF_NUM_SLAVES*32-1:0] DEF_SLV_MASK =
        {GPOUT_MASK, GPIN_MASK, SPI_MASK, MEM_MASK};

    // The error slot sits one past the last real slave index.
    function automatic int errCode(input int numSlaves);
        return numSlaves;
    endfunction

    // Bits needed to hold any slave index 0..numSlaves-1 plus the error code.
    function automatic int idxWidth(input int numSlaves);
        return (numSlaves < 1) ? 1 : $clog2(numSlaves + 1);
    endfunction

endpackage

// File: rtl/xbar_resp_fifo.sv
// ---------------------------------------------------------------------------
// xbar_resp_fifo
// Small synchronous FIFO remembering, in issue order, which target owes the
// next response.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, din     write an entry (ignored while full)
//   pop           drop the head entry (ignored while empty)
//   dout          head entry, valid while !empty
//   empty, full   occupancy flags
//   count         number of stored entries
// ---------------------------------------------------------------------------
module xbar_resp_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             doPush, doPop;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign count  = count_q;
    assign dout   = mem_q[rdPtr_q];
    assign doPush = push & ~full;
    assign doPop  = pop & ~empty;

    // Pointer and occupancy update. Pointers wrap explicitly at DEPTH-1 so
    // the FIFO also behaves for DEPTH == 1; a simultaneous push and pop
    // leaves the count unchanged.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = (wrPtr_q == PW'(DEPTH - 1)) ? '0 : wrPtr_q + PW'(1);
        end
        if (doPop) begin
            rdPtr_d = (rdPtr_q == PW'(DEPTH - 1)) ? '0 : rdPtr_q + PW'(1);
        end
        if (doPush && !doPop) begin
            count_d = count_q + CW'(1);
        end else if (doPop && !doPush) begin
            count_d = count_q - CW'(1);
        end
    end

    // State registers plus the entry storage; reset empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            if (doPush) begin
                mem_q[wrPtr_q] <= din;
            end
        end
    end

endmodule

// File: rtl/data_bus_xbar.sv
// ---------------------------------------------------------------------------
// data_bus_xbar
// Routes one req/gnt/rvalid data port to NUM_SLAVES targets using a base/mask
// address map. Up to MAX_OUTST granted transactions may be pending; responses
// are returned strictly in issue order. Unmapped addresses get an error
// response, and out-of-order or unsolicited slave responses set a sticky flag.
// Ports:
//   HCLK, HRESET                 clock, asynchronous active-high reset
//   data_req/addr/we/be/wdata    core request side
//   data_gnt                     request accepted this cycle
//   data_rvalid/rdata/err        core response side
//   s_req                        per-slave request (one-hot or zero)
//   s_addr/we/be/wdata           unregistered broadcast of the core request
//   s_gnt, s_rvalid, s_rdata     per-slave grant and response (rdata flat)
//   outst_cnt                    pending transactions
//   proto_err                    sticky slave protocol violation
// ---------------------------------------------------------------------------
module data_bus_xbar
    import data_bus_pkg::*;
#(
    parameter int                         NUM_SLAVES = DEF_NUM_SLAVES,
    parameter int                         MAX_OUTST  = 2,
    parameter logic [NUM_SLAVES*32-1:0]   SLV_BASE   = DEF_SLV_BASE,
    parameter logic [NUM_SLAVES*32-1:0]   SLV_MASK   = DEF_SLV_MASK,
    parameter logic [31:0]                ERR_RDATA  = 32'h0000_0000
) (
    input  logic                           HCLK,
    input  logic                           HRESET,
    input  logic                           data_req,
    input  logic [31:0]                    data_addr,
    input  logic                           data_we,
    input  logic [3:0]                     data_be,
    input  logic [31:0]                    data_wdata,
    output logic                           data_gnt,
    output logic                           data_rvalid,
    output logic [31:0]                    data_rdata,
    output logic                           data_err,
    output logic [NUM_SLAVES-1:0]          s_req,
    output logic [31:0]                    s_addr,
    output logic                           s_we,
    output logic [3:0]                     s_be,
    output logic [31:0]                    s_wdata,
    input  logic [NUM_SLAVES-1:0]          s_gnt,
    input  logic [NUM_SLAVES-1:0]          s_rvalid,
    input  logic [NUM_SLAVES*32-1:0]       s_rdata,
    output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt,
    output logic                           proto_err
);

    localparam int             IW      = idxWidth(NUM_SLAVES);
    localparam logic [IW-1:0]  ERR_IDX = IW'(errCode(NUM_SLAVES));

    logic [NUM_SLAVES-1:0] hit, sel, unexpected;
    logic [IW-1:0]         selIdx, pushIdx, headIdx;
    logic                  miss, fifoEmpty, fifoFull;
    logic                  protoErr_q, protoErr_d;

    // Address decode. Every window is checked; the lowest matching index
    // wins so overlapping windows still give a one-hot select.
    always_comb begin
        hit    = '0;
        sel    = '0;
        selIdx = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            hit[i] = ((data_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]);
        end
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel    = '0;
                sel[i] = 1'b1;
                selIdx = IW'(i);
            end
        end
    end

    // Request side. Nothing is issued while the FIFO is full, even if a
    // response retires in the same cycle, which keeps rvalid out of the gnt
    // path. Outputs are also forced low while reset is held.
    assign miss     = data_req & ~|hit;
    assign s_req    = {NUM_SLAVES{data_req & ~fifoFull & ~HRESET}} & sel;
    assign data_gnt = (|(s_req & s_gnt) | (miss & ~fifoFull)) & ~HRESET;
    assign pushIdx  = miss ? ERR_IDX : selIdx;

    assign s_addr  = data_addr;
    assign s_we    = data_we;
    assign s_be    = data_be;
    assign s_wdata = data_wdata;

    xbar_resp_fifo #(
        .WIDTH (IW),
        .DEPTH (MAX_OUTST)
    ) u_resp_fifo (
        .clk   (HCLK),
        .rst   (HRESET),
        .push  (data_gnt),
        .pop   (data_rvalid),
        .din   (pushIdx),
        .dout  (headIdx),
        .empty (fifoEmpty),
        .full  (fifoFull),
        .count (outst_cnt)
    );

    // Response side. The FIFO head names the only slave allowed to answer;
    // an ERR head answers by itself one cycle after it was pushed at the
    // earliest. Any slave rvalid not matching the head is flagged and dropped.
    always_comb begin
        data_rvalid = 1'b0;
        data_rdata  = '0;
        data_err    = 1'b0;
        unexpected  = s_rvalid;
        if (!fifoEmpty) begin
            if (headIdx == ERR_IDX) begin
                data_rvalid = 1'b1;
                data_rdata  = ERR_RDATA;
                data_err    = 1'b1;
            end else begin
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    if (headIdx == IW'(i)) begin
                        data_rvalid   = s_rvalid[i];
                        data_rdata    = s_rdata[32*i +: 32];
                        unexpected[i] = 1'b0;
                    end
                end
            end
        end
    end

    assign protoErr_d = protoErr_q | (|unexpected);
    assign proto_err  = protoErr_q;

    // Sticky protocol-error flag; only reset clears it.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            protoErr_q <= 1'b0;
        end else begin
            protoErr_q <= protoErr_d;
        end
    end

endmodule

// File: tb/tb_data_bus_xbar.sv
// ---------------------------------------------------------------------------
// tb_data_bus_xbar
// Self-checking bench for data_bus_xbar. Slaves are driven procedurally per
// scenario; expected responses are queued when a grant is seen and compared
// when data_rvalid appears.
// ---------------------------------------------------------------------------
module tb_data_bus_xbar;
    import data_bus_pkg::*;

    localparam logic [31:0] TB_ERR_RDATA = 32'hBAD0_ADD5;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic         HCLK;
    logic         HRESET;
    logic         data_req;
    logic [31:0]  data_addr;
    logic         data_we;
    logic [3:0]   data_be;
    logic [31:0]  data_wdata;
    logic         data_gnt;
    logic         data_rvalid;
    logic [31:0]  data_rdata;
    logic         data_err;
    logic [3:0]   s_req;
    logic [31:0]  s_addr;
    logic         s_we;
    logic [3:0]   s_be;
    logic [31:0]  s_wdata;
    logic [3:0]   s_gnt;
    logic [3:0]   s_rvalid;
    logic [127:0] s_rdata;
    logic [1:0]   outst_cnt;
    logic         proto_err;

    int    total = 0;
    int    bad   = 0;
    resp_t expQ[$];
    resp_t expR;

    data_bus_xbar #(
        .NUM_SLAVES (4),
        .MAX_OUTST  (2),
        .SLV_BASE   (DEF_SLV_BASE),
        .SLV_MASK   (DEF_SLV_MASK),
        .ERR_RDATA  (TB_ERR_RDATA)
    ) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .data_req    (data_req),
        .data_addr   (data_addr),
        .data_we     (data_we),
        .data_be     (data_be),
        .data_wdata  (data_wdata),
        .data_gnt    (data_gnt),
        .data_rvalid (data_rvalid),
        .data_rdata  (data_rdata),
        .data_err    (data_err),
        .s_req       (s_req),
        .s_addr      (s_addr),
        .s_we        (s_we),
        .s_be        (s_be),
        .s_wdata     (s_wdata),
        .s_gnt       (s_gnt),
        .s_rvalid    (s_rvalid),
        .s_rdata     (s_rdata),
        .outst_cnt   (outst_cnt),
        .proto_err   (proto_err)
    );

    // Free-running 100 MHz clock.
    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // Hard stop in case a scenario goes astray.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Move to just after the next rising edge, where inputs are changed.
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Drive the core request inputs.
    task automatic applyStimulus(input logic req, input logic [31:0] addr, input logic we,
                                 input logic [3:0] be, input logic [31:0] wdata);
        data_req   = req;
        data_addr  = addr;
        data_we    = we;
        data_be    = be;
        data_wdata = wdata;
    endtask

    // Reset values, including a mapped request held during reset.
    task automatic test_reset();
        HRESET = 1'b1;
        applyStimulus(1'b1, 32'h0010_0000, 1'b0, 4'hF, 32'h0);
        s_gnt = 4'hF; s_rvalid = '0; s_rdata = '0;
        tick(); tick();
        #1;
        total++; if (data_gnt !== 1'b0) begin bad++; $display("[TB] FAIL rst_gnt: got %b want 0", data_gnt); end
        total++; if (s_req !== 4'b0000) begin bad++; $display("[TB] FAIL rst_sreq: got %b want 0000", s_req); end
        total++; if ({data_rvalid, data_err} !== 2'b00) begin bad++; $display("[TB] FAIL rst_rvalid_err: got %b want 00", {data_rvalid, data_err}); end
        total++; if (data_rdata !== 32'h0) begin bad++; $display("[TB] FAIL rst_rdata: got %h want 0", data_rdata); end
        total++; if (outst_cnt !== 2'd0) begin bad++; $display("[TB] FAIL rst_cnt: got %0d want 0", outst_cnt); end
        total++; if (proto_err !== 1'b0) begin bad++; $display("[TB] FAIL rst_proto: got %b want 0", proto_err); end
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        s_gnt = '0;
        HRESET = 1'b0;
        tick();
    endtask

    // One read from slave 0, granted at once, answered two cycles later.
    task automatic test_single_read();
        applyStimulus(1'b1, 32'h0010_0010, 1'b0, 4'hF, 32'h0);
        s_gnt = 4'b0001;
        #1;
        total++; if (s_req !== 4'b0001) begin bad++; $display("[TB] FAIL sr_sreq: got %b want 0001", s_req); end
        total++; if (data_gnt !== 1'b1) begin bad++; $display("[TB] FAIL sr_gnt: got %b want 1", data_gnt); end
        if (data_gnt === 1'b1) expQ.push_back('{32'hCAFE_F00D, 1'b0});
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        s_gnt = '0;
        #1;
        total++; if (outst_cnt !== 2'd1) begin bad++; $display("[TB] FAIL sr_cnt1: got %0d want 1", outst_cnt); end
        total++; if (data_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL sr_early_rvalid: got %b want 0", data_rvalid); end
        tick();
        s_rvalid = 4'b0001; s_rdata[0 +: 32] = 32'hCAFE_F00D;
        #1;
        total++;
        if (data_rvalid !== 1'b1) begin bad++; $display("[TB] FAIL sr_rvalid: got %b want 1", data_rvalid); end
        else if (expQ.size() == 0) begin bad++; $display("[TB] FAIL sr_sb: got response want none queued"); end
        else begin
            expR = expQ.pop_front();
            if (data_rdata !== expR.rdata || data_err !== expR.err) begin bad++; $display("[TB] FAIL sr_resp: got %h/%b want %h/%b", data_rdata, data_err, expR.rdata, expR.err); end
        end
        tick();
        s_rvalid = '0;
        #1;
        total++; if (outst_cnt !== 2'd0) begin bad++; $display("[TB] FAIL sr_cnt0: got %0d want 0", outst_cnt); end
    endtask

    // Unmapped address: grant with no slave request, error response next cycle.
    task automatic test_error_resp();
        applyStimulus(1'b1, 32'h3000_0000, 1'b0, 4'hF, 32'h0);
        #1;
        total++; if (s_req !== 4'b0000) begin bad++; $display("[TB] FAIL er_sreq: got %b want 0000", s_req); end
        total++; if (data_gnt !== 1'b1) begin bad++; $display("[TB] FAIL er_gnt: got %b want 1", data_gnt); end
        if (data_gnt === 1'b1) expQ.push_back('{TB_ERR_RDATA, 1'b1});
        total++; if (data_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL er_same_cycle: got %b want 0", data_rvalid); end
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        #1;
        total++;
        if (data_rvalid !== 1'b1) begin bad++; $display("[TB] FAIL er_rvalid: got %b want 1", data_rvalid); end
        else if (expQ.size() == 0) begin bad++; $display("[TB] FAIL er_sb: got response want none queued"); end
        else begin
            expR = expQ.pop_front();
            if (data_rdata !== expR.rdata || data_err !== expR.err) begin bad++; $display("[TB] FAIL er_resp: got %h/%b want %h/%b", data_rdata, data_err, expR.rdata, expR.err); end
        end
        tick();
        #1;
        total++; if ({data_rvalid, outst_cnt} !== 3'b000) begin bad++; $display("[TB] FAIL er_after: got rvalid=%b cnt=%0d want 0/0", data_rvalid, outst_cnt); end
    endtask

    // Write to slave 2 with the grant withheld for three cycles.
    task automatic test_write_stall();
        applyStimulus(1'b1, 32'h2000_1004, 1'b1, 4'b0110, 32'h1234_5678);
        s_gnt = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (data_gnt !== 1'b0) begin bad++; $display("[TB] FAIL ws_stall_gnt%0d: got %b want 0", c, data_gnt); end
            total++; if (s_req !== 4'b0100) begin bad++; $display("[TB] FAIL ws_sreq%0d: got %b want 0100", c, s_req); end
            tick();
        end
        total++; if ({s_addr, s_we, s_be, s_wdata} !== {32'h2000_1004, 1'b1, 4'b0110, 32'h1234_5678}) begin bad++; $display("[TB] FAIL ws_bcast: got %h %b %b %h want 20001004 1 0110 12345678", s_addr, s_we, s_be, s_wdata); end
        s_gnt = 4'b0100;
        #1;
        total++; if (data_gnt !== 1'b1) begin bad++; $display("[TB] FAIL ws_gnt: got %b want 1", data_gnt); end
        if (data_gnt === 1'b1) expQ.push_back('{32'h0000_0001, 1'b0});
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        s_gnt = '0;
        tick();
        s_rvalid = 4'b0100; s_rdata[64 +: 32] = 32'h0000_0001;
        #1;
        total++;
        if (data_rvalid !== 1'b1) begin bad++; $display("[TB] FAIL ws_rvalid: got %b want 1", data_rvalid); end
        else if (expQ.size() == 0) begin bad++; $display("[TB] FAIL ws_sb: got response want none queued"); end
        else begin
            expR = expQ.pop_front();
            if (data_rdata !== expR.rdata || data_err !== expR.err) begin bad++; $display("[TB] FAIL ws_resp: got %h/%b want %h/%b", data_rdata, data_err, expR.rdata, expR.err); end
        end
        tick();
        s_rvalid = '0;
    endtask

    // Unsolicited response with nothing pending.
    task automatic test_unsolicited();
        #1;
        total++; if (proto_err !== 1'b0) begin bad++; $display("[TB] FAIL us_before: got %b want 0", proto_err); end
        s_rvalid = 4'b0010; s_rdata[32 +: 32] = 32'h5555_AAAA;
        #1;
        total++; if (data_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL us_rvalid: got %b want 0", data_rvalid); end
        tick();
        s_rvalid = '0;
        #1;
        total++; if (proto_err !== 1'b1) begin bad++; $display("[TB] FAIL us_set: got %b want 1", proto_err); end
        tick(); tick();
        #1;
        total++; if ({proto_err, data_rvalid, outst_cnt} !== 4'b1000) begin bad++; $display("[TB] FAIL us_sticky: got proto=%b rvalid=%b cnt=%0d want 1/0/0", proto_err, data_rvalid, outst_cnt); end
    endtask

    // Reset with two transactions pending, then a normal read.
    task automatic test_reset_midop();
        s_gnt = 4'b0110;
        applyStimulus(1'b1, 32'h2000_0000, 1'b0, 4'hF, 32'h0);
        tick();
        applyStimulus(1'b1, 32'h2000_1000, 1'b0, 4'hF, 32'h0);
        tick();
        #1;
        total++; if (outst_cnt !== 2'd2) begin bad++; $display("[TB] FAIL rm_pending: got %0d want 2", outst_cnt); end
        HRESET = 1'b1;
        #1;
        total++; if (outst_cnt !== 2'd0) begin bad++; $display("[TB] FAIL rm_cnt: got %0d want 0", outst_cnt); end
        total++; if ({data_gnt, s_req, data_rvalid, data_err, proto_err} !== 8'h00) begin bad++; $display("[TB] FAIL rm_outs: got gnt=%b sreq=%b rv=%b err=%b proto=%b want all 0", data_gnt, s_req, data_rvalid, data_err, proto_err); end
        total++; if (data_rdata !== 32'h0) begin bad++; $display("[TB] FAIL rm_rdata: got %h want 0", data_rdata); end
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        s_gnt = '0;
        tick(); tick();
        HRESET = 1'b0;
        tick();
        applyStimulus(1'b1, 32'h2000_0008, 1'b0, 4'hF, 32'h0);
        s_gnt = 4'b0010;
        #1;
        total++; if ({data_gnt, s_req} !== 5'b1_0010) begin bad++; $display("[TB] FAIL rm_regnt: got gnt=%b sreq=%b want 1/0010", data_gnt, s_req); end
        if (data_gnt === 1'b1) expQ.push_back('{32'h0BAD_F00D, 1'b0});
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        s_gnt = '0;
        s_rvalid = 4'b0010; s_rdata[32 +: 32] = 32'h0BAD_F00D;
        #1;
        total++;
        if (data_rvalid !== 1'b1) begin bad++; $display("[TB] FAIL rm_rvalid: got %b want 1", data_rvalid); end
        else if (expQ.size() == 0) begin bad++; $display("[TB] FAIL rm_sb: got response want none queued"); end
        else begin
            expR = expQ.pop_front();
            if (data_rdata !== expR.rdata || data_err !== expR.err) begin bad++; $display("[TB] FAIL rm_resp: got %h/%b want %h/%b", data_rdata, data_err, expR.rdata, expR.err); end
        end
        tick();
        s_rvalid = '0;
        #1;
        total++; if ({outst_cnt, proto_err} !== 3'b000) begin bad++; $display("[TB] FAIL rm_after: got cnt=%0d proto=%b want 0/0", outst_cnt, proto_err); end
    endtask

    // Slave 0 (latency 3) then slave 3 (latency 1), a third request stalls
    // while full; slave 3 answers early and holds rvalid until its turn.
    task automatic test_back_to_back();
        s_gnt = 4'b1001;
        applyStimulus(1'b1, 32'h0010_0020, 1'b0, 4'hF, 32'h0);
        #1;
        total++; if ({data_gnt, s_req} !== 5'b1_0001) begin bad++; $display("[TB] FAIL bb_gnt_a: got gnt=%b sreq=%b want 1/0001", data_gnt, s_req); end
        if (data_gnt === 1'b1) expQ.push_back('{32'hA0A0_0000, 1'b0});
        tick();
        applyStimulus(1'b1, 32'h2000_2000, 1'b0, 4'hF, 32'h0);
        #1;
        total++; if ({data_gnt, s_req} !== 5'b1_1000) begin bad++; $display("[TB] FAIL bb_gnt_b: got gnt=%b sreq=%b want 1/1000", data_gnt, s_req); end
        if (data_gnt === 1'b1) expQ.push_back('{32'hB3B3_0003, 1'b0});
        tick();
        applyStimulus(1'b1, 32'h0010_0030, 1'b0, 4'hF, 32'h0);
        s_rvalid = 4'b1000; s_rdata[96 +: 32] = 32'hB3B3_0003;
        #1;
        total++; if ({data_gnt, s_req, outst_cnt} !== 7'b0_0000_10) begin bad++; $display("[TB] FAIL bb_full: got gnt=%b sreq=%b cnt=%0d want 0/0000/2", data_gnt, s_req, outst_cnt); end
        total++; if (data_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL bb_order: got rvalid=%b want 0", data_rvalid); end
        tick();
        s_rvalid = 4'b1001; s_rdata[0 +: 32] = 32'hA0A0_0000;
        #1;
        total++; if (proto_err !== 1'b1) begin bad++; $display("[TB] FAIL bb_proto: got %b want 1", proto_err); end
        total++; if (data_gnt !== 1'b0) begin bad++; $display("[TB] FAIL bb_gnt_popfull: got %b want 0", data_gnt); end
        total++;
        if (data_rvalid !== 1'b1) begin bad++; $display("[TB] FAIL bb_rvalid_a: got %b want 1", data_rvalid); end
        else if (expQ.size() == 0) begin bad++; $display("[TB] FAIL bb_sb_a: got response want none queued"); end
        else begin
            expR = expQ.pop_front();
            if (data_rdata !== expR.rdata || data_err !== expR.err) begin bad++; $display("[TB] FAIL bb_resp_a: got %h/%b want %h/%b", data_rdata, data_err, expR.rdata, expR.err); end
        end
        tick();
        s_rvalid = 4'b1000;
        #1;
        total++;
        if (data_rvalid !== 1'b1) begin bad++; $display("[TB] FAIL bb_rvalid_b: got %b want 1", data_rvalid); end
        else if (expQ.size() == 0) begin bad++; $display("[TB] FAIL bb_sb_b: got response want none queued"); end
        else begin
            expR = expQ.pop_front();
            if (data_rdata !== expR.rdata || data_err !== expR.err) begin bad++; $display("[TB] FAIL bb_resp_b: got %h/%b want %h/%b", data_rdata, data_err, expR.rdata, expR.err); end
        end
        total++; if ({data_gnt, s_req} !== 5'b1_0001) begin bad++; $display("[TB] FAIL bb_gnt_c: got gnt=%b sreq=%b want 1/0001", data_gnt, s_req); end
        if (data_gnt === 1'b1) expQ.push_back('{32'hC0C0_0000, 1'b0});
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        s_rvalid = '0;
        s_gnt = '0;
        #1;
        total++; if (outst_cnt !== 2'd1) begin bad++; $display("[TB] FAIL bb_cnt_pushpop: got %0d want 1", outst_cnt); end
        tick();
        s_rvalid = 4'b0001; s_rdata[0 +: 32] = 32'hC0C0_0000;
        #1;
        total++;
        if (data_rvalid !== 1'b1) begin bad++; $display("[TB] FAIL bb_rvalid_c: got %b want 1", data_rvalid); end
        else if (expQ.size() == 0) begin bad++; $display("[TB] FAIL bb_sb_c: got response want none queued"); end
        else begin
            expR = expQ.pop_front();
            if (data_rdata !== expR.rdata || data_err !== expR.err) begin bad++; $display("[TB] FAIL bb_resp_c: got %h/%b want %h/%b", data_rdata, data_err, expR.rdata, expR.err); end
        end
        tick();
        s_rvalid = '0;
        #1;
        total++; if ({outst_cnt, proto_err} !== 3'b001) begin bad++; $display("[TB] FAIL bb_end: got cnt=%0d proto=%b want 0/1", outst_cnt, proto_err); end
    endtask

    initial begin
        $display("[TB] starting data_bus_xbar bench");
        test_reset();
        test_single_read();
        test_error_resp();
        test_write_stall();
        test_unsolicited();
        test_reset_midop();
        test_back_to_back();
        total++; if (expQ.size() != 0) begin bad++; $display("[TB] FAIL sb_drain: got %0d left want 0", expQ.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
